// File: rtl/matmul_pkg.sv
// Shared types and constants for the tiled matrix-multiply sequencer.
// Holds the coordinate/step widths, the controller state encoding and the tile-count helper.
package matmul_pkg;

  localparam int IDX_W   = 10;
  localparam int STEPS_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_MUL = 3'd1,
    S_WAIT_MUL  = 3'd2,
    S_ISSUE_ADD = 3'd3,
    S_WAIT_ADD  = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  // Number of tiles of size den needed to cover num elements.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/matmul_tile_sched_tile_iter.sv
// Three-level wrapping tile-origin counter: k innermost, then column, then row.
// Origins are kept directly (index * tile size) so they drive the datapath from flops.
module tile_iter
  import matmul_pkg::*;
#(
  parameter int TR = 1,
  parameter int TC = 1,
  parameter int TK = 1,
  parameter int J  = 1,
  parameter int K  = 1,
  parameter int L  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic [IDX_W-1:0] k_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'((TR - 1) * J);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'((TC - 1) * K);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'((TK - 1) * L);
  localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(J);
  localparam logic [IDX_W-1:0] COL_STEP = IDX_W'(K);
  localparam logic [IDX_W-1:0] K_STEP   = IDX_W'(L);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             row_end_s, col_end_s, k_end_s;

  assign row_end_s = (row_q == ROW_LAST);
  assign col_end_s = (col_q == COL_LAST);
  assign k_end_s   = (k_q == K_LAST);

  // Next-origin computation with inner-first carry.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    k_d   = k_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
    end else if (adv_i) begin
      if (!k_end_s) begin
        k_d = k_q + K_STEP;
      end else begin
        k_d = '0;
        if (!col_end_s) begin
          col_d = col_q + COL_STEP;
        end else begin
          col_d = '0;
          if (!row_end_s) begin
            row_d = row_q + ROW_STEP;
          end else begin
            row_d = '0;
          end
        end
      end
    end else begin
      k_d = k_q;
    end
  end

  // Origin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign k_o    = k_q;
  assign last_o = row_end_s & col_end_s & k_end_s;

endmodule

// File: rtl/matmul_tile_sched.sv
// Tile scheduler: walks all output/inner tiles, firing multiplier then adder per step.
// Pulses and status are decoded from the state register; coordinates come from tile_iter flops.
module matmul_tile_sched
  import matmul_pkg::*;
#(
  parameter int A_M = 4,
  parameter int A_N = 4,
  parameter int B_N = 4,
  parameter int J   = 2,
  parameter int K   = 2,
  parameter int L   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               mul_start_o,
  output logic [IDX_W-1:0]   mul_row_o,
  output logic [IDX_W-1:0]   mul_col_o,
  output logic [IDX_W-1:0]   mul_k_o,
  input  logic               mul_done_i,
  output logic               add_start_o,
  output logic [IDX_W-1:0]   add_row_o,
  output logic [IDX_W-1:0]   add_col_o,
  input  logic               add_done_i,
  output logic [STEPS_W-1:0] steps_done_o
);

  localparam int TR = ceil_div(A_M, J);
  localparam int TC = ceil_div(B_N, K);
  localparam int TK = ceil_div(A_N, L);

  state_e             state_q, state_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic               clr_s, adv_s, last_s;
  logic [IDX_W-1:0]   row_s, col_s, k_s;

  tile_iter #(
    .TR(TR), .TC(TC), .TK(TK),
    .J (J),  .K (K),  .L (L)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_s),
    .adv_i (adv_s),
    .row_o (row_s),
    .col_o (col_s),
    .k_o   (k_s),
    .last_o(last_s)
  );

  // Next-state, step counter and iterator control.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    clr_s   = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE_MUL;
          steps_d = '0;
          clr_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE_MUL: state_d = S_WAIT_MUL;
      S_WAIT_MUL: begin
        if (mul_done_i) state_d = S_ISSUE_ADD;
        else            state_d = S_WAIT_MUL;
      end
      S_ISSUE_ADD: state_d = S_WAIT_ADD;
      S_WAIT_ADD: begin
        if (add_done_i) state_d = S_NEXT;
        else            state_d = S_WAIT_ADD;
      end
      S_NEXT: begin
        adv_s = 1'b1;
        if (steps_q != '1) steps_d = steps_q + STEPS_W'(1);
        else               steps_d = steps_q;
        if (last_s) state_d = S_DONE;
        else        state_d = S_ISSUE_MUL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake seen in the same cycle and freezes the count.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      steps_d = steps_q;
      adv_s   = 1'b0;
    end else begin
      clr_s = clr_s;
    end
  end

  // State and step-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign mul_start_o  = (state_q == S_ISSUE_MUL);
  assign add_start_o  = (state_q == S_ISSUE_ADD);
  assign mul_row_o    = row_s;
  assign mul_col_o    = col_s;
  assign mul_k_o      = k_s;
  assign add_row_o    = row_s;
  assign add_col_o    = col_s;
  assign steps_done_o = steps_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Self-checking bench: three parameterisations share stimulus; a nested-loop tile model
// supplies expected coordinates, step counts and completion cycles.
module tb_matmul_tile_sched;

  logic clk = 1'b0;
  logic rst;
  logic start_i, abort_i, mul_done_i, add_done_i;

  logic       busy_w [3];
  logic       done_w [3];
  logic       mul_start_w [3];
  logic       add_start_w [3];
  logic [9:0] mul_row_w [3];
  logic [9:0] mul_col_w [3];
  logic [9:0] mul_k_w [3];
  logic [9:0] add_row_w [3];
  logic [9:0] add_col_w [3];
  logic [15:0] steps_w [3];

  int vectors = 0;
  int miscompares = 0;

  int exp_r[$];
  int exp_c[$];
  int exp_k[$];

  typedef struct {
    int dut;
    int am, an, bn, j, k, l;
    int mul_delay;
    bit poke_start;
    int exp_steps;
    int exp_done_cyc;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  matmul_tile_sched #(.A_M(4), .A_N(4), .B_N(4), .J(2), .K(2), .L(2)) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .mul_start_o(mul_start_w[0]),
    .mul_row_o(mul_row_w[0]), .mul_col_o(mul_col_w[0]), .mul_k_o(mul_k_w[0]),
    .mul_done_i(mul_done_i), .add_start_o(add_start_w[0]),
    .add_row_o(add_row_w[0]), .add_col_o(add_col_w[0]), .add_done_i(add_done_i),
    .steps_done_o(steps_w[0]));

  matmul_tile_sched #(.A_M(3), .A_N(1), .B_N(5), .J(2), .K(2), .L(2)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .mul_start_o(mul_start_w[1]),
    .mul_row_o(mul_row_w[1]), .mul_col_o(mul_col_w[1]), .mul_k_o(mul_k_w[1]),
    .mul_done_i(mul_done_i), .add_start_o(add_start_w[1]),
    .add_row_o(add_row_w[1]), .add_col_o(add_col_w[1]), .add_done_i(add_done_i),
    .steps_done_o(steps_w[1]));

  matmul_tile_sched #(.A_M(1), .A_N(1), .B_N(1), .J(2), .K(2), .L(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .mul_start_o(mul_start_w[2]),
    .mul_row_o(mul_row_w[2]), .mul_col_o(mul_col_w[2]), .mul_k_o(mul_k_w[2]),
    .mul_done_i(mul_done_i), .add_start_o(add_start_w[2]),
    .add_row_o(add_row_w[2]), .add_col_o(add_col_w[2]), .add_done_i(add_done_i),
    .steps_done_o(steps_w[2]));

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: enumerate tile origins rows outer, columns, inner depth innermost.
  task automatic build_expected(input int am, input int an, input int bn,
                                input int j, input int k, input int l);
    exp_r.delete(); exp_c.delete(); exp_k.delete();
    for (int r = 0; r < am; r += j)
      for (int c = 0; c < bn; c += k)
        for (int kk = 0; kk < an; kk += l) begin
          exp_r.push_back(r); exp_c.push_back(c); exp_k.push_back(kk);
        end
  endtask

  function automatic bit any_busy();
    return busy_w[0] | busy_w[1] | busy_w[2];
  endfunction

  task automatic wait_all_idle();
    for (int i = 0; i < 200 && any_busy(); i++) tick();
    check("idle_timeout", any_busy(), 0);
  endtask

  task automatic check_all_zero(input string name, input int d);
    check(name, |{busy_w[d], done_w[d], mul_start_w[d], add_start_w[d], mul_row_w[d],
                  mul_col_w[d], mul_k_w[d], add_row_w[d], add_col_w[d], steps_w[d]}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int d, nmul, nadd, ndone, cur, since;
    bit pending;
    d = v.dut;
    build_expected(v.am, v.an, v.bn, v.j, v.k, v.l);
    nmul = 0; nadd = 0; ndone = 0; cur = -1; since = 0; pending = 1'b0;
    mul_done_i = (v.mul_delay == 0);
    add_done_i = 1'b1;
    start_i = 1'b1;
    tick();
    for (int cyc = 1; cyc <= v.exp_done_cyc + 5; cyc++) begin
      if (mul_start_w[d]) begin
        cur = nmul; nmul++; pending = 1'b1; since = 0;
        if (cur < exp_r.size()) begin
          check("mul_row", mul_row_w[d], exp_r[cur]);
          check("mul_col", mul_col_w[d], exp_c[cur]);
          check("mul_k",   mul_k_w[d],   exp_k[cur]);
        end else begin
          check("extra_mul_start", nmul, exp_r.size());
        end
      end else if (busy_w[d] && !done_w[d] && cur >= 0 && cur < exp_r.size()) begin
        check("coord_stable", {mul_row_w[d], mul_col_w[d], mul_k_w[d]},
              {10'(exp_r[cur]), 10'(exp_c[cur]), 10'(exp_k[cur])});
      end
      if (add_start_w[d]) begin
        nadd++; pending = 1'b0;
        if (cur >= 0 && cur < exp_r.size()) begin
          check("add_row", add_row_w[d], exp_r[cur]);
          check("add_col", add_col_w[d], exp_c[cur]);
        end
      end
      if (done_w[d]) begin
        ndone++;
        check("done_cycle", cyc, v.exp_done_cyc);
        check("steps_at_done", steps_w[d], exp_r.size());
      end
      if (cyc > v.exp_done_cyc) check("busy_after_done", busy_w[d], 0);
      if (v.mul_delay > 0) begin
        mul_done_i = pending && (since >= 1 + v.mul_delay);
        since++;
      end
      start_i = v.poke_start && (cyc == 7 || cyc == 20 || cyc == v.exp_done_cyc);
      tick();
    end
    start_i = 1'b0;
    check("mul_start_count", nmul, exp_r.size());
    check("add_start_count", nadd, exp_r.size());
    check("done_count", ndone, 1);
    check("steps_final", steps_w[d], v.exp_steps);
  endtask

  initial begin
    vecs[0] = '{dut: 0, am: 4, an: 4, bn: 4, j: 2, k: 2, l: 2, mul_delay: 0, poke_start: 1'b0, exp_steps: 8, exp_done_cyc: 41};
    vecs[1] = '{dut: 1, am: 3, an: 1, bn: 5, j: 2, k: 2, l: 2, mul_delay: 0, poke_start: 1'b0, exp_steps: 6, exp_done_cyc: 31};
    vecs[2] = '{dut: 0, am: 4, an: 4, bn: 4, j: 2, k: 2, l: 2, mul_delay: 3, poke_start: 1'b0, exp_steps: 8, exp_done_cyc: 65};
    vecs[3] = '{dut: 2, am: 1, an: 1, bn: 1, j: 2, k: 2, l: 2, mul_delay: 0, poke_start: 1'b0, exp_steps: 1, exp_done_cyc: 6};
    vecs[4] = '{dut: 0, am: 4, an: 4, bn: 4, j: 2, k: 2, l: 2, mul_delay: 0, poke_start: 1'b1, exp_steps: 8, exp_done_cyc: 41};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    mul_done_i = 1'b1; add_done_i = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) check_all_zero("reset_outputs", d);
    #3 rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) check("idle_after_reset", busy_w[d], 0);

    for (int i = 0; i < 5; i++) begin
      wait_all_idle();
      run_vec(vecs[i]);
    end

    // Abort coinciding with mul_done in step 3 (WAIT_MUL is cycle 12).
    wait_all_idle();
    mul_done_i = 1'b1; add_done_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    check("step3_mul_start", mul_start_w[0], 1);
    check("step3_coords", {mul_row_w[0], mul_col_w[0], mul_k_w[0]}, {10'd0, 10'd2, 10'd0});
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", busy_w[0], 0);
    check("abort_no_add", add_start_w[0], 0);
    check("abort_steps", steps_w[0], 2);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", done_w[0] | add_start_w[0] | mul_start_w[0], 0);
      tick();
    end
    check("abort_steps_held", steps_w[0], 2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("restart_mul_start", mul_start_w[0], 1);
    check("restart_coords", {mul_row_w[0], mul_col_w[0], mul_k_w[0]}, 30'd0);
    check("restart_steps", steps_w[0], 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_in_issue", busy_w[0], 0);

    // Asynchronous reset in WAIT_ADD of step 2 (cycle 9, k origin 2).
    wait_all_idle();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    check("pre_rst_k", mul_k_w[0], 2);
    check("pre_rst_busy", busy_w[0], 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst_outputs", 0);
    #4 rst = 1'b0;
    tick();
    check("post_rst_busy", busy_w[0] | mul_start_w[0] | add_start_w[0] | done_w[0], 0);
    tick();
    check("post_rst_idle", busy_w[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sched.md
# matmul_tile_sched

Sequencing controller for the tiled matrix-multiply datapath. On one `start` it walks every output tile of the A_M x B_N result and every inner-dimension tile of A_N. For each step it fires the block multiplier, then the block adder, with a done-handshake on each. The adder accumulates each product into the result buffer. The block sits between the host/command interface and the multiplier/adder pair, and owns all tile coordinates driven to them.

## Interface
- `A_M`, 4: result rows (1..1023)
- `A_N`, 4: inner dimension (1..1023)
- `B_N`, 4: result columns (1..1023)
- `J`, 2: tile rows
- `K`, 2: tile columns
- `L`, 2: inner tile depth
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  run request; honoured only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE, no `done`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of a full run
- `mul_start`  out  1  one-cycle pulse to the multiplier
- `mul_row`, `mul_col`, `mul_k`  out  10 each  tile origin: row, column, inner offset
- `mul_done`  in  1  multiplier result valid
- `add_start`  out  1  one-cycle pulse to the adder
- `add_row`, `add_col`  out  10 each  accumulate target origin
- `add_done`  in  1  adder complete (level)
- `steps_done`  out  16  count of completed mul+add steps in current/last run

## Operation
- Tile counts: TR=ceil(A_M/J), TC=ceil(B_N/K), TK=ceil(A_N/L). Total steps T=TR*TC*TK.
- Loop order: row tile (outer), column tile, inner tile (innermost).
- Coordinates are tile index times tile size (row*J, col*K, k*L).
- Partial edge tiles are issued unchanged; the datapath masks out-of-range elements.
- States:
  - IDLE: `start` -> ISSUE_MUL; clears counters and `steps_done`.
  - ISSUE_MUL: `mul_start`=1 -> WAIT_MUL.
  - WAIT_MUL: stays until `mul_done` -> ISSUE_ADD.
  - ISSUE_ADD: `add_start`=1 -> WAIT_ADD.
  - WAIT_ADD: stays until `add_done` -> NEXT.
  - NEXT: `steps_done`+1, advance counters. If the last step is done -> DONE, else -> ISSUE_MUL.
  - DONE: `done`=1 -> IDLE.
- Counters wrap inner-first: k wraps to 0 and carries into col, col wraps and carries into row.
- `add_row`/`add_col` equal `mul_row`/`mul_col`. Coordinates are held stable from ISSUE_MUL through NEXT.
- `mul_done` is sampled only in WAIT_MUL; `add_done` only in WAIT_ADD. Stale-high levels in other states are ignored.
- `start` while busy is ignored. `start` in the same cycle as DONE is ignored.
- `abort` in any non-IDLE state -> IDLE next edge. No `done`; `steps_done` is held.
- `abort` beats a simultaneous `mul_done`/`add_done`.
- `steps_done` saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, all outputs 0, all coordinates 0.
- Reset mid-run aborts immediately and asynchronously; no pulses follow.
- `start` sampled at edge 0 -> ISSUE_MUL in cycle 1.
- With `mul_done`/`add_done` already high on the first wait cycle, each step takes 5 cycles. `done` is high in cycle 5T+1.
- Each wait cycle without the handshake adds one cycle.
- All outputs are registered or decoded from the state register; no combinational input-to-output path.

## Structure
- Shared package `matmul_pkg`:
  - index width (10) and `steps_done` width (16);
  - state enum;
  - ceil-divide function used for TR/TC/TK.
- Sub-module `tile_iter`: three-level wrapping counter.
  - Inputs: `clr`, `adv`.
  - Outputs: `row`/`col`/`k` origins and `last`.
  - `last` = all three indices at their final tile.
- The FSM and handshake logic live in `matmul_tile_sched`.

## Test plan
- Default params, handshakes tied high: `start` -> 8 `mul_start`/`add_start` pairs. (row,col,k) run (0,0,0),(0,0,2),(0,2,0),(0,2,2),(2,0,0)…(2,2,2). `done` at cycle 41, `steps_done`=8.
- A_M=3,B_N=5,A_N=1, J=K=L=2: 6 steps, origins rows {0,2}, cols {0,2,4}, k=0 only. `done` once.
- `mul_done` delayed 3 cycles, `add_done` held high before `add_start`: stale `add_done` is ignored, each step takes 8 cycles, coordinates stay stable.
- `abort` together with `mul_done` in step 3: IDLE next cycle, no `add_start`, no `done`, `steps_done`=2. A new `start` restarts at (0,0,0).
- `rst` asserted mid WAIT_ADD: all outputs 0 immediately. `start` during busy: no effect on sequence or count.
- A_M=B_N=A_N=1: single step, `done` at cycle 6.
